prm_edge_sweep: RTL and testbench

PRM_EDGE_SWEEP -- requirements
Module: prm_edge_sweep

---
 rtl/prm_sweep_pkg.sv | 18 +
 rtl/prm_joint_interp.sv | 24 ++
 rtl/prm_edge_sweep.sv | 110 +++++++++++
 tb/tb_prm_edge_sweep.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/prm_sweep_pkg.sv
// Shared definitions for the PRM edge sweeper: FSM encoding, default geometry, code width.
package prm_sweep_pkg;

  localparam int JW_DEF        = 5;
  localparam int NJ_DEF        = 3;
  localparam int STEP_LOG2_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cw_of(input int nj, input int jw);
    return nj * jw;
  endfunction

endpackage

// File: rtl/prm_joint_interp.sv
// One joint of the edge interpolator: sample = a + floor((b-a)*k / 2^STEP_LOG2).
module prm_joint_interp
  import prm_sweep_pkg::*;
#(
  parameter int JW        = JW_DEF,
  parameter int STEP_LOG2 = STEP_LOG2_DEF
) (
  input  logic [JW-1:0]      a,
  input  logic [JW-1:0]      b,
  input  logic [STEP_LOG2:0] k,
  output logic [JW-1:0]      sample
);

  localparam int PW = JW + STEP_LOG2 + 2;

  logic signed [JW:0]   diff;
  logic signed [PW-1:0] prod;

  assign diff = $signed({1'b0, b}) - $signed({1'b0, a});
  // k <= 2^STEP_LOG2 keeps |prod| below 2^(PW-1), so PW bits never overflow.
  assign prod = PW'(diff) * PW'($signed({1'b0, k}));
  assign sample = JW'((prod >>> STEP_LOG2) + $signed({{(STEP_LOG2 + 2){1'b0}}, a}));

endmodule

// File: rtl/prm_edge_sweep.sv
// PRM edge sweeper: issues N+1 interpolated samples to a checker bank and reports the first blocked one.
// Optional build macro PRM_SWEEP_EARLY_EXIT_EN ends the sweep at the first blocked sample.
module prm_edge_sweep
  import prm_sweep_pkg::*;
#(
  parameter  int JW        = JW_DEF,
  parameter  int NJ        = NJ_DEF,
  parameter  int STEP_LOG2 = STEP_LOG2_DEF,
  localparam int CW        = cw_of(NJ, JW),
  localparam int KW        = STEP_LOG2 + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [CW-1:0] cfg_a,
  input  logic [CW-1:0] cfg_b,
  output logic [CW-1:0] chk_code,
  output logic          chk_valid,
  input  logic          chk_mask,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_free,
  output logic [KW-1:0] res_hit_idx
);

  localparam logic [KW-1:0] K_LAST = KW'(1 << STEP_LOG2);

  state_t        state;
  logic [CW-1:0] a_q;
  logic [CW-1:0] b_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_nxt;
  logic [CW-1:0] code_nxt;
  logic          hit_q;
  logic          sweep_end;

  assign start_ready = (state == IDLE);
  assign k_nxt       = k_q + KW'(1);

  // chk_code is registered, so the interpolators look one sample ahead.
  for (genvar j = 0; j < NJ; j++) begin : g_joint
    prm_joint_interp #(
      .JW        (JW),
      .STEP_LOG2 (STEP_LOG2)
    ) u_interp (
      .a      (a_q[j*JW +: JW]),
      .b      (b_q[j*JW +: JW]),
      .k      (k_nxt),
      .sample (code_nxt[j*JW +: JW])
    );
  end

`ifdef PRM_SWEEP_EARLY_EXIT_EN
  assign sweep_end = (k_q == K_LAST) || chk_mask;
`else
  assign sweep_end = (k_q == K_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      chk_code    <= '0;
      chk_valid   <= 1'b0;
      res_valid   <= 1'b0;
      res_free    <= 1'b0;
      res_hit_idx <= '0;
      hit_q       <= 1'b0;
      k_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_q         <= cfg_a;
            b_q         <= cfg_b;
            chk_code    <= cfg_a;
            chk_valid   <= 1'b1;
            k_q         <= '0;
            hit_q       <= 1'b0;
            res_hit_idx <= '0;
            state       <= SWEEP;
          end
        end
        SWEEP: begin
          if (chk_mask && !hit_q) begin
            hit_q       <= 1'b1;
            res_hit_idx <= k_q;
          end
          if (sweep_end) begin
            chk_valid <= 1'b0;
            res_valid <= 1'b1;
            res_free  <= !(hit_q || chk_mask);
            state     <= DONE;
          end else begin
            k_q      <= k_nxt;
            chk_code <= code_nxt;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_sweep.sv
// Randomized and directed self-checking bench for prm_edge_sweep against an arithmetic reference model.
module tb_prm_edge_sweep;

  localparam int JW = 5;
  localparam int NJ = 3;
  localparam int SL = 3;
  localparam int N  = 1 << SL;
  localparam int CW = NJ * JW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [CW-1:0] cfg_a;
  logic [CW-1:0] cfg_b;
  logic [CW-1:0] chk_code;
  logic          chk_valid;
  logic          chk_mask;
  logic          res_valid;
  logic          res_ready;
  logic          res_free;
  logic [SL:0]   res_hit_idx;

  int n_chk  = 0;
  int n_pass = 0;

  prm_edge_sweep #(.JW(JW), .NJ(NJ), .STEP_LOG2(SL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cfg_a       (cfg_a),
    .cfg_b       (cfg_b),
    .chk_code    (chk_code),
    .chk_valid   (chk_valid),
    .chk_mask    (chk_mask),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_free    (res_free),
    .res_hit_idx (res_hit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact rational interpolation with floor rounding.
  function automatic int joint_ref(input int a, input int b, input int k);
    int p;
    p = (b - a) * k;
    if (p >= 0) return a + p / N;
    else        return a - ((-p + N - 1) / N);
  endfunction

  function automatic logic [CW-1:0] code_ref(input logic [CW-1:0] a, input logic [CW-1:0] b, input int k);
    logic [CW-1:0] r;
    r = '0;
    for (int j = 0; j < NJ; j++)
      r[j*JW +: JW] = JW'(joint_ref(int'(a[j*JW +: JW]), int'(b[j*JW +: JW]), k));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one edge; mask[k]=1 blocks sample k; hold = DONE cycles before res_ready.
  task automatic run_edge(input logic [CW-1:0] a, input logic [CW-1:0] b,
                          input logic [N:0] mask, input int hold, input int rst_at);
    int first;
    int lastk;
    logic [CW-1:0] last_code;
    first = -1;
    for (int k = 0; k <= N; k++) if (mask[k] && first < 0) first = k;
`ifdef PRM_SWEEP_EARLY_EXIT_EN
    lastk = (first >= 0) ? first : N;
`else
    lastk = N;
`endif
    check("start_ready_idle", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    cfg_a = a;
    cfg_b = b;
    tick();
    for (int k = 0; k <= lastk; k++) begin
      start_valid = 1'($urandom_range(0, 1));
      cfg_a = CW'($urandom);
      chk_mask = mask[k];
      check("chk_valid_sweep", 32'(chk_valid), 32'd1);
      check("chk_code", 32'(chk_code), 32'(code_ref(a, b, k)));
      check("start_ready_sweep", 32'(start_ready), 32'd0);
      check("res_valid_sweep", 32'(res_valid), 32'd0);
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_mask = 1'b0;
        start_valid = 1'b0;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_chk_valid", 32'(chk_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_chk_code", 32'(chk_code), 32'd0);
        check("rst_hit_idx", 32'(res_hit_idx), 32'd0);
        return;
      end
      tick();
    end
    chk_mask = 1'b0;
    last_code = code_ref(a, b, lastk);
    for (int h = 0; h <= hold; h++) begin
      start_valid = 1'($urandom_range(0, 1));
      res_ready = (h == hold);
      check("res_valid_done", 32'(res_valid), 32'd1);
      check("res_free", 32'(res_free), 32'(first < 0));
      check("res_hit_idx", 32'(res_hit_idx), (first < 0) ? 32'd0 : 32'(first));
      check("chk_valid_done", 32'(chk_valid), 32'd0);
      check("chk_code_hold", 32'(chk_code), 32'(last_code));
      check("start_ready_done", 32'(start_ready), 32'd0);
      if (h == hold) start_valid = 1'b0;
      tick();
    end
    res_ready = 1'b0;
    check("idle_after_ready", 32'(start_ready), 32'd1);
    check("res_valid_idle", 32'(res_valid), 32'd0);
    check("chk_valid_idle", 32'(chk_valid), 32'd0);
  endtask

  initial begin
    logic [CW-1:0] ra;
    logic [CW-1:0] rb;
    logic [N:0]    rm;
    rst = 1'b1;
    start_valid = 1'b0;
    cfg_a = '0;
    cfg_b = '0;
    chk_mask = 1'b0;
    res_ready = 1'b0;
    tick();
    start_valid = 1'b1;
    tick();
    rst = 1'b0;
    start_valid = 1'b0;
    check("reset_start_ready", 32'(start_ready), 32'd1);
    check("reset_chk_valid", 32'(chk_valid), 32'd0);
    check("reset_chk_code", 32'(chk_code), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_free", 32'(res_free), 32'd0);
    check("reset_hit_idx", 32'(res_hit_idx), 32'd0);

    run_edge('0, '0, '0, 0, -1);
    run_edge(CW'(2), CW'(10), '0, 0, -1);
    run_edge(CW'(10), CW'(3), '0, 0, -1);
    run_edge(CW'(31) | (CW'(0) << 5) | (CW'(17) << 10), CW'(0) | (CW'(31) << 5) | (CW'(17) << 10), '0, 1, -1);
    run_edge(CW'(5), CW'(20), 9'b0_0001_0000, 0, -1);
    run_edge(CW'(7), CW'(1), 9'b0_0100_0100, 0, -1);
    run_edge(CW'(12345), CW'(54321), 9'b1_0000_0000, 0, -1);
    run_edge(CW'(3), CW'(29), 9'b0_0000_0001, 5, -1);
    run_edge(CW'(9), CW'(30), '0, 0, 3);
    run_edge(CW'(9), CW'(30), 9'b0_0010_0000, 2, -1);

    for (int t = 0; t < 40; t++) begin
      ra = CW'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : CW'($urandom);
      rm = '0;
      for (int k = 0; k <= N; k++) rm[k] = ($urandom_range(0, 9) == 0);
      run_edge(ra, rb, rm, $urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? $urandom_range(0, N) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
